// File: rtl/led_sequencer.sv
// RSLK chassis LED sequencer: one shared step timer walks FR/FL/BR/BL through four button-selected patterns.
// Optional macro LED_SEQ_DIM_EN adds 8-bit PWM dimming of lit LEDs (DIM_DUTY/256 duty).
module led_sequencer #(
    parameter int TICK_COUNT     = 16000000,
    parameter int CNT_W          = 27,
    parameter int DEB_CYCLES     = 160000,
    parameter bit BTN_ACTIVE_LOW = 1'b1
`ifdef LED_SEQ_DIM_EN
    ,
    parameter int DIM_DUTY       = 64
`endif
) (
    input  logic       WF_CLK,
    input  logic       rst,
    input  logic       WF_BUTTON,
    input  logic       en,
    output logic       ledFR,
    output logic       ledFL,
    output logic       ledBR,
    output logic       ledBL,
    output logic [1:0] mode,
    output logic       step_tick
);

    localparam int   DEB_W        = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic BTN_IDLE_RAW = BTN_ACTIVE_LOW;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    logic             btnMeta_r;
    logic             btnSync_r;
    logic             btnNorm_s;
    logic [DEB_W-1:0] debCnt_r;
    logic             debLevel_r;
    logic             debPrev_r;
    logic             pressEvt_s;
    state_t           state_r;
    state_t           stateNxt_s;
    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] timerNxt_s;
    logic [1:0]       step_r;
    logic [1:0]       stepNxt_s;
    logic [1:0]       mode_r;
    logic [1:0]       modeNxt_s;
    logic             tick_r;
    logic             tickNxt_s;
    logic [3:0]       pattern_s;
    logic [3:0]       led_r;

    // Index of the last step of each pattern; step wraps to 0 after it.
    function automatic logic [1:0] lastStep(input logic [1:0] m);
        case (m)
            2'd0:    lastStep = 2'd1;
            2'd1:    lastStep = 2'd3;
            2'd2:    lastStep = 2'd1;
            default: lastStep = 2'd0;
        endcase
    endfunction

    // Pattern table as {FR,FL,BR,BL}; ROTATE walks FR -> BR -> BL -> FL.
    function automatic logic [3:0] ledPattern(input logic [1:0] m, input logic [1:0] s);
        case ({m, s})
            4'b00_00: ledPattern = 4'b0011;
            4'b00_01: ledPattern = 4'b1100;
            4'b01_00: ledPattern = 4'b1000;
            4'b01_01: ledPattern = 4'b0010;
            4'b01_10: ledPattern = 4'b0001;
            4'b01_11: ledPattern = 4'b0100;
            4'b10_00: ledPattern = 4'b1111;
            default:  ledPattern = 4'b0000;
        endcase
    endfunction

    // Two-flop synchroniser; reset to the released raw level so no false press follows reset.
    always_ff @(posedge WF_CLK or posedge rst) begin
        if (rst) begin
            btnMeta_r <= BTN_IDLE_RAW;
            btnSync_r <= BTN_IDLE_RAW;
        end else begin
            btnMeta_r <= WF_BUTTON;
            btnSync_r <= btnMeta_r;
        end
    end

    assign btnNorm_s  = BTN_ACTIVE_LOW ? ~btnSync_r : btnSync_r;
    assign pressEvt_s = debLevel_r & ~debPrev_r;

    // Debouncer: accept a new level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge WF_CLK or posedge rst) begin
        if (rst) begin
            debCnt_r   <= '0;
            debLevel_r <= 1'b0;
            debPrev_r  <= 1'b0;
        end else begin
            debPrev_r <= debLevel_r;
            if (btnNorm_s != debLevel_r) begin
                if (debCnt_r == DEB_W'(DEB_CYCLES - 1)) begin
                    debLevel_r <= btnNorm_s;
                    debCnt_r   <= '0;
                end else begin
                    debCnt_r <= debCnt_r + DEB_W'(1);
                end
            end else begin
                debCnt_r <= '0;
            end
        end
    end

    // Next-state logic; a press outranks both the timer terminal and the step advance.
    always_comb begin
        stateNxt_s = state_r;
        timerNxt_s = timer_r;
        stepNxt_s  = step_r;
        modeNxt_s  = mode_r;
        tickNxt_s  = 1'b0;
        if (pressEvt_s) begin
            modeNxt_s = mode_r + 2'd1;
        end else begin
            modeNxt_s = mode_r;
        end
        case (state_r)
            S_IDLE: begin
                timerNxt_s = '0;
                stepNxt_s  = 2'd0;
                if (en) begin
                    stateNxt_s = S_RUN;
                end else begin
                    stateNxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (!en) begin
                    stateNxt_s = S_IDLE;
                    timerNxt_s = '0;
                    stepNxt_s  = 2'd0;
                end else if (pressEvt_s || (mode_r == 2'd3)) begin
                    timerNxt_s = '0;
                    stepNxt_s  = 2'd0;
                end else if (timer_r == CNT_W'(TICK_COUNT - 1)) begin
                    timerNxt_s = '0;
                    tickNxt_s  = 1'b1;
                    if (step_r >= lastStep(mode_r)) begin
                        stepNxt_s = 2'd0;
                    end else begin
                        stepNxt_s = step_r + 2'd1;
                    end
                end else begin
                    timerNxt_s = timer_r + CNT_W'(1);
                end
            end
            default: begin
                stateNxt_s = S_IDLE;
                timerNxt_s = '0;
                stepNxt_s  = 2'd0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge WF_CLK or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            timer_r <= '0;
            step_r  <= 2'd0;
            mode_r  <= 2'd0;
            tick_r  <= 1'b0;
        end else begin
            state_r <= stateNxt_s;
            timer_r <= timerNxt_s;
            step_r  <= stepNxt_s;
            mode_r  <= modeNxt_s;
            tick_r  <= tickNxt_s;
        end
    end

    // Decode the lit pattern from registered state so the LED register lags it by one clock.
    always_comb begin
        if (state_r == S_RUN) begin
            pattern_s = ledPattern(mode_r, step_r);
        end else begin
            pattern_s = 4'b0000;
        end
    end

`ifdef LED_SEQ_DIM_EN
    logic [7:0] pwmCnt_r;
    logic       pwmOn_s;

    assign pwmOn_s = ({24'd0, pwmCnt_r} < DIM_DUTY);

    // Free-running PWM counter and dimmed LED register.
    always_ff @(posedge WF_CLK or posedge rst) begin
        if (rst) begin
            pwmCnt_r <= 8'd0;
            led_r    <= 4'b0000;
        end else begin
            pwmCnt_r <= pwmCnt_r + 8'd1;
            led_r    <= pattern_s & {4{pwmOn_s}};
        end
    end
`else
    // Full-brightness LED register.
    always_ff @(posedge WF_CLK or posedge rst) begin
        if (rst) begin
            led_r <= 4'b0000;
        end else begin
            led_r <= pattern_s;
        end
    end
`endif

    assign ledFR     = led_r[3];
    assign ledFL     = led_r[2];
    assign ledBR     = led_r[1];
    assign ledBL     = led_r[0];
    assign mode      = mode_r;
    assign step_tick = tick_r;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer (TICK_COUNT=4, DEB_CYCLES=3, active-low button).
// With LED_SEQ_DIM_EN defined a second instance measures PWM duty over a 256-cycle window.
module tb_led_sequencer;

    logic       WF_CLK    = 1'b0;
    logic       rst       = 1'b1;
    logic       WF_BUTTON = 1'b1;
    logic       en        = 1'b0;
    logic       ledFR, ledFL, ledBR, ledBL;
    logic [1:0] mode;
    logic       step_tick;
    logic [3:0] leds;
    int         nVec = 0;
    int         nErr = 0;

    assign leds = {ledFR, ledFL, ledBR, ledBL};

    always #5 WF_CLK = ~WF_CLK;

    led_sequencer #(
        .TICK_COUNT(4),
        .CNT_W(27),
        .DEB_CYCLES(3),
        .BTN_ACTIVE_LOW(1'b1)
`ifdef LED_SEQ_DIM_EN
        ,
        .DIM_DUTY(256)
`endif
    ) dut (
        .WF_CLK(WF_CLK), .rst(rst), .WF_BUTTON(WF_BUTTON), .en(en),
        .ledFR(ledFR), .ledFL(ledFL), .ledBR(ledBR), .ledBL(ledBL),
        .mode(mode), .step_tick(step_tick)
    );

`ifdef LED_SEQ_DIM_EN
    logic       btn2 = 1'b1;
    logic       en2  = 1'b0;
    logic       d2FR, d2FL, d2BR, d2BL;
    logic [1:0] mode2;
    logic       tick2;

    led_sequencer #(
        .TICK_COUNT(600),
        .CNT_W(10),
        .DEB_CYCLES(3),
        .BTN_ACTIVE_LOW(1'b1),
        .DIM_DUTY(64)
    ) dut2 (
        .WF_CLK(WF_CLK), .rst(rst), .WF_BUTTON(btn2), .en(en2),
        .ledFR(d2FR), .ledFL(d2FL), .ledBR(d2BR), .ledBL(d2BL),
        .mode(mode2), .step_tick(tick2)
    );
`endif

    task automatic cyc();
        @(posedge WF_CLK);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        nVec++;
        if (leds !== 4'b0000) begin nErr++; $display("FAIL reset_leds got=%b exp=0000", leds); end
        nVec++;
        if (mode !== 2'd0) begin nErr++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        nVec++;
        if (step_tick !== 1'b0) begin nErr++; $display("FAIL reset_tick got=%b exp=0", step_tick); end
    endtask

    task automatic test_run();
        logic [3:0] expL;
        logic       expT;
        rst = 1'b0;
        en  = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            cyc();
            if (n < 2) expL = 4'b0000;
            else if (((n - 2) / 4) % 2 == 0) expL = 4'b0011;
            else expL = 4'b1100;
            expT = (n >= 5) && ((n - 5) % 4 == 0);
            nVec++;
            if (leds !== expL) begin nErr++; $display("FAIL run_leds n=%0d got=%b exp=%b", n, leds, expL); end
            nVec++;
            if (step_tick !== expT) begin nErr++; $display("FAIL run_tick n=%0d got=%b exp=%b", n, step_tick, expT); end
        end
        nVec++;
        if (mode !== 2'd0) begin nErr++; $display("FAIL run_mode got=%0d exp=0", mode); end
    endtask

    task automatic test_mode_cycling();
        logic [1:0] expM [3];
        logic [3:0] expL [3];
        logic [3:0] rot;
        expM = '{2'd2, 2'd3, 2'd0};
        expL = '{4'b1111, 4'b0000, 4'b0011};
        WF_BUTTON = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            cyc();
            if (k == 10) WF_BUTTON = 1'b1;
            if (k == 5 || k == 6) begin
                nVec++;
                if (mode !== ((k == 6) ? 2'd1 : 2'd0)) begin nErr++; $display("FAIL press1_mode k=%0d got=%0d", k, mode); end
            end
            if (k == 7 || k == 11 || k == 15 || k == 19 || k == 23) begin
                case (k)
                    7:       rot = 4'b1000;
                    11:      rot = 4'b0010;
                    15:      rot = 4'b0001;
                    19:      rot = 4'b0100;
                    default: rot = 4'b1000;
                endcase
                nVec++;
                if (leds !== rot) begin nErr++; $display("FAIL rotate_leds k=%0d got=%b exp=%b", k, leds, rot); end
            end
        end
        for (int p = 0; p < 3; p++) begin
            WF_BUTTON = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                cyc();
                if (k == 10) WF_BUTTON = 1'b1;
                if (k == 6) begin
                    nVec++;
                    if (mode !== expM[p]) begin nErr++; $display("FAIL cycle_mode got=%0d exp=%0d", mode, expM[p]); end
                end
                if (k == 7) begin
                    nVec++;
                    if (leds !== expL[p]) begin nErr++; $display("FAIL cycle_leds got=%b exp=%b", leds, expL[p]); end
                end
                if (expM[p] == 2'd3 && k >= 7) begin
                    nVec++;
                    if (step_tick !== 1'b0) begin nErr++; $display("FAIL off_tick k=%0d got=%b exp=0", k, step_tick); end
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [1:0] expM;
        for (int w = 1; w <= 3; w++) begin
            WF_BUTTON = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                cyc();
                if (k == w) WF_BUTTON = 1'b1;
                if (k == 5 || k == 6 || k == 20) begin
                    expM = (w == 3 && k >= 6) ? 2'd1 : 2'd0;
                    nVec++;
                    if (mode !== expM) begin nErr++; $display("FAIL bounce_mode w=%0d k=%0d got=%0d exp=%0d", w, k, mode, expM); end
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        en = 1'b0;
        cyc();
        cyc();
        en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == 3) WF_BUTTON = 1'b0;
            if (k == 13) WF_BUTTON = 1'b1;
            if (k == 5 || k == 9 || k == 13) begin
                nVec++;
                if (step_tick !== (k != 9)) begin nErr++; $display("FAIL terminal_tick k=%0d got=%b exp=%b", k, step_tick, (k != 9)); end
            end
            if (k == 9) begin
                nVec++;
                if (mode !== 2'd2) begin nErr++; $display("FAIL terminal_mode got=%0d exp=2", mode); end
            end
            if (k == 10 || k == 14) begin
                nVec++;
                if (leds !== ((k == 10) ? 4'b1111 : 4'b0000)) begin nErr++; $display("FAIL terminal_leds k=%0d got=%b", k, leds); end
            end
        end
        WF_BUTTON = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == 5) en = 1'b0;
            if (k == 10) WF_BUTTON = 1'b1;
            if (k == 5 || k == 6) begin
                nVec++;
                if (mode !== ((k == 6) ? 2'd3 : 2'd2)) begin nErr++; $display("FAIL enfall_mode k=%0d got=%0d", k, mode); end
            end
            if (k == 7 || k == 12) begin
                nVec++;
                if (leds !== 4'b0000) begin nErr++; $display("FAIL enfall_leds k=%0d got=%b exp=0000", k, leds); end
                nVec++;
                if (step_tick !== 1'b0) begin nErr++; $display("FAIL enfall_tick k=%0d got=%b exp=0", k, step_tick); end
            end
        end
    endtask

    task automatic test_reset_midrun();
        for (int p = 0; p < 3; p++) begin
            WF_BUTTON = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                cyc();
                if (k == 10) WF_BUTTON = 1'b1;
                if (k == 6) begin
                    nVec++;
                    if (mode !== 2'(p)) begin nErr++; $display("FAIL idle_press_mode got=%0d exp=%0d", mode, p); end
                end
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            if (k >= 2) begin
                nVec++;
                if (leds !== 4'b1111) begin nErr++; $display("FAIL blink_leds k=%0d got=%b exp=1111", k, leds); end
            end
        end
        #3;
        rst = 1'b1;
        #1;
        nVec++;
        if ({leds, mode, step_tick} !== 7'd0) begin nErr++; $display("FAIL async_rst got=%b exp=0000000", {leds, mode, step_tick}); end
        cyc();
        cyc();
        rst = 1'b0;
        en  = 1'b0;
        repeat (3) cyc();
        nVec++;
        if (mode !== 2'd0) begin nErr++; $display("FAIL post_rst_mode got=%0d exp=0", mode); end
        nVec++;
        if (leds !== 4'b0000) begin nErr++; $display("FAIL post_rst_leds got=%b exp=0000", leds); end
    endtask

`ifdef LED_SEQ_DIM_EN
    task automatic test_dim();
        int onCnt [4];
        int offCnt [4];
        logic [3:0] d2;
        for (int i = 0; i < 4; i++) begin onCnt[i] = 0; offCnt[i] = 0; end
        for (int p = 0; p < 2; p++) begin
            btn2 = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                cyc();
                if (k == 10) btn2 = 1'b1;
            end
        end
        nVec++;
        if (mode2 !== 2'd2) begin nErr++; $display("FAIL dim_mode got=%0d exp=2", mode2); end
        en2 = 1'b1;
        for (int k = 1; k <= 1000; k++) begin
            cyc();
            d2 = {d2FR, d2FL, d2BR, d2BL};
            for (int i = 0; i < 4; i++) begin
                if (k >= 10 && k <= 265 && d2[i] === 1'b1) onCnt[i]++;
                if (k >= 700 && k <= 955 && d2[i] !== 1'b0) offCnt[i]++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            nVec++;
            if (onCnt[i] !== 64) begin nErr++; $display("FAIL dim_on led=%0d got=%0d exp=64", i, onCnt[i]); end
            nVec++;
            if (offCnt[i] !== 0) begin nErr++; $display("FAIL dim_off led=%0d got=%0d exp=0", i, offCnt[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_run();
        test_mode_cycling();
        test_bounce();
        test_simultaneous();
        test_reset_midrun();
`ifdef LED_SEQ_DIM_EN
        test_dim();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Controller for the TI-RSLK chassis LEDs (FR, FL, BR, BL) on the WebFPGA Shasta board. A single shared step timer sequences the four LEDs through one of four selectable patterns. A debounced WF_BUTTON press cycles the pattern mode, and an enable input starts and stops sequencing. All LED outputs are registered and drive the RSLK LED pins directly.

Parameters:
TICK_COUNT, 16000000, clocks per pattern step (1 s at 16 MHz); must be >= 2
CNT_W, 27, width of the step timer; must satisfy 2^CNT_W > TICK_COUNT
DEB_CYCLES, 160000, consecutive stable samples required to accept a button level (10 ms); must be >= 1
BTN_ACTIVE_LOW, 1, 1 = WF_BUTTON reads 0 when pressed; 0 = reads 1 when pressed

Ports:
WF_CLK  input  1  system clock; all logic on the rising edge
rst  input  1  reset; asynchronous, active-high
WF_BUTTON  input  1  raw mode-select pushbutton; asynchronous to WF_CLK
en  input  1  1 = run the sequence; 0 = idle with LEDs off
ledFR  output  1  front-right LED
ledFL  output  1  front-left LED
ledBR  output  1  back-right LED
ledBL  output  1  back-left LED
mode  output  2  current pattern mode
step_tick  output  1  one-cycle pulse each time the step advances

Behaviour:
- Reset (asynchronous, immediate):
  - all LEDs = 0, mode = 0, step = 0, timer = 0, step_tick = 0
  - state = S_IDLE; debounce counter = 0; debounced level = released
  - reset mid-sequence aborts with no partial step
- Button path:
  - 2-flop synchroniser on WF_BUTTON, then polarity-normalise using BTN_ACTIVE_LOW
  - debounced level updates only after DEB_CYCLES consecutive cycles in which the synchronised level differs from the current debounced level; any bounce resets the count
  - press event = debounced released->pressed transition, one cycle wide; release produces no event
- Mode register:
  - each press event: mode <= mode + 1, wrapping 3 -> 0
  - presses are accepted in any state, including S_IDLE
  - each press event also forces step <= 0 and timer <= 0
- FSM states:
  - S_IDLE: timer and step held at 0; LEDs off; go to S_RUN when en = 1
  - S_RUN: timer counts 0..TICK_COUNT-1
    - when timer == TICK_COUNT-1: timer <= 0; step <= (step+1) mod steps(mode); step_tick = 1 on that edge
    - en = 0: go to S_IDLE on the next edge, clearing timer and step
- Patterns, as {FR,FL,BR,BL} per step:
  - mode 0 ALT (2 steps): 0011, 1100
  - mode 1 ROTATE (4 steps): 1000, 0010, 0001, 0100, i.e. FR -> BR -> BL -> FL
  - mode 2 BLINK (2 steps): 1111, 0000
  - mode 3 OFF (1 step): 0000; timer does not run, step_tick never fires
- Latency:
  - LED registers are decoded from the registered state/mode/step and update one clock after those change
  - the first step of a run is visible 2 clocks after en rises: 1 to enter S_RUN, 1 for the LED register
- Simultaneous events:
  - press plus timer terminal: the press wins; step = 0, timer = 0, no step_tick
  - press plus en falling: go to S_IDLE and still advance mode
- Wrap-around: step never exceeds steps(mode)-1; a mode change while step = 3 (ROTATE) is safe because step clears.

Optional Feature:
LED_SEQ_DIM_EN
- Defined:
  - adds an 8-bit free-running PWM counter and a parameter DIM_DUTY, default 64
  - lit LEDs are driven 1 only while pwm_cnt < DIM_DUTY (about 25% brightness)
  - off LEDs stay 0; step timing is unchanged
- Undefined: lit LEDs are driven at a constant 1; no PWM logic is synthesised.

Test Plan:
1. Reset and run: TICK_COUNT=4, DEB_CYCLES=3, en=1 after reset -> mode=0; LEDs {FR,FL,BR,BL}=0011 from cycle 2; step_tick every 4 cycles; pattern alternates 0011/1100.
2. Mode cycling: 4 clean presses, each held 10 cycles -> mode sequence 1,2,3,0; each press restarts at step 0; in mode 1 the LEDs rotate 1000, 0010, 0001, 0100, 1000.
3. Bounce rejection: pulses on WF_BUTTON of 1-2 cycles with DEB_CYCLES=3 -> mode unchanged; a 3-cycle stable press -> mode +1 exactly once.
4. Simultaneous events: press event landing on the timer-terminal cycle -> no step_tick, step = 0; en dropped together with a press -> S_IDLE, LEDs 0000, mode advanced.
5. Reset mid-run: rst asserted asynchronously mid-step in mode 2 -> all outputs 0 with no clock edge needed; mode = 0 after release.
6. LED_SEQ_DIM_EN defined with DIM_DUTY=64 in BLINK mode -> each LED duty is exactly 64/256 during the on step and 0 during the off step.
